// File: rtl/system_bus_arbiter.sv
// Two-master round-robin arbiter for the CPU system bus (m0 = fetch, m1 = load/store).
// A grant stays locked until accepted; an in-order ID FIFO routes read responses back to their issuer.
module system_bus_arbiter #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,

  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,

  input  logic        system_bus_ready,
  output logic [31:0] system_bus_addr,
  output logic [31:0] system_bus_write_data,
  output logic [3:0]  system_bus_byte_enable,
  output logic        system_bus_write_req,
  output logic        system_bus_read_req,
  input  logic [31:0] system_bus_read_data,
  input  logic        system_bus_read_data_valid,

  output logic        unexpected_read_data
);

  localparam int PTR_W = $clog2(OUTSTANDING_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(OUTSTANDING_DEPTH);

  logic                         lock;
  logic                         lock_id;
  logic                         rr_ptr;
  logic [OUTSTANDING_DEPTH-1:0] id_fifo;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [PTR_W:0]               count;

  logic fifo_full;
  logic fifo_empty;
  logic req0;
  logic req1;
  logic grant_valid;
  logic grant_id;
  logic g_read;
  logic g_write;
  logic g_ready;
  logic accept;
  logic push;
  logic pop;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign req0       = m0_read_req | m0_write_req;
  assign req1       = m1_read_req | m1_write_req;

  // Outputs are gated by reset so the bus is quiet for the whole reset window.
  always_comb begin
    grant_valid            = 1'b0;
    grant_id               = 1'b0;
    g_read                 = 1'b0;
    g_write                = 1'b0;
    system_bus_addr        = '0;
    system_bus_write_data  = '0;
    system_bus_byte_enable = '0;
    system_bus_write_req   = 1'b0;
    system_bus_read_req    = 1'b0;

    if (!reset) begin
      if (lock) begin
        grant_valid = 1'b1;
        grant_id    = lock_id;
      end else if (req0 && req1) begin
        grant_valid = 1'b1;
        grant_id    = rr_ptr;
      end else if (req0) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end

    if (grant_valid) begin
      g_read                 = grant_id ? m1_read_req    : m0_read_req;
      g_write                = grant_id ? m1_write_req   : m0_write_req;
      system_bus_addr        = grant_id ? m1_addr        : m0_addr;
      system_bus_write_data  = grant_id ? m1_write_data  : m0_write_data;
      system_bus_byte_enable = grant_id ? m1_byte_enable : m0_byte_enable;
      system_bus_write_req   = g_write;
      system_bus_read_req    = g_read && !fifo_full;
    end
  end

  // fifo_full is registered, so a response in this cycle cannot unblock a read this cycle.
  assign g_ready  = grant_valid && system_bus_ready && !(g_read && fifo_full);
  assign m0_ready = g_ready && !grant_id;
  assign m1_ready = g_ready && grant_id;
  assign accept   = g_ready && (g_read || g_write);
  assign push     = accept && g_read;
  assign pop      = system_bus_read_data_valid && !fifo_empty && !reset;

  assign m0_read_data       = system_bus_read_data;
  assign m1_read_data       = system_bus_read_data;
  assign m0_read_data_valid = pop && !id_fifo[head];
  assign m1_read_data_valid = pop && id_fifo[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock    <= 1'b0;
      lock_id <= 1'b0;
      rr_ptr  <= 1'b0;
    end else if (accept) begin
      lock    <= 1'b0;
      rr_ptr  <= ~grant_id;
    end else if (grant_valid && (g_read || g_write)) begin
      lock    <= 1'b1;
      lock_id <= grant_id;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_fifo              <= '0;
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      unexpected_read_data <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[tail] <= grant_id;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end
      if (system_bus_read_data_valid && fifo_empty) begin
        unexpected_read_data <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Directed bench for system_bus_arbiter: stimulus pushes expected read responses,
// a negedge monitor pops and compares them whenever either master sees read_data_valid.
module tb_system_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_write_data, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_write_req, m1_write_req;
  logic        m0_read_req, m1_read_req;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_read_data_valid, m1_read_data_valid;
  logic        system_bus_ready;
  logic [31:0] system_bus_addr;
  logic [31:0] system_bus_write_data;
  logic [3:0]  system_bus_byte_enable;
  logic        system_bus_write_req;
  logic        system_bus_read_req;
  logic [31:0] system_bus_read_data;
  logic        system_bus_read_data_valid;
  logic        unexpected_read_data;

  int compared   = 0;
  int mismatched = 0;
  logic [32:0] exp_q[$];

  system_bus_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .m0_ready                   (m0_ready),
    .m0_addr                    (m0_addr),
    .m0_write_data              (m0_write_data),
    .m0_byte_enable             (m0_byte_enable),
    .m0_write_req               (m0_write_req),
    .m0_read_req                (m0_read_req),
    .m0_read_data               (m0_read_data),
    .m0_read_data_valid         (m0_read_data_valid),
    .m1_ready                   (m1_ready),
    .m1_addr                    (m1_addr),
    .m1_write_data              (m1_write_data),
    .m1_byte_enable             (m1_byte_enable),
    .m1_write_req               (m1_write_req),
    .m1_read_req                (m1_read_req),
    .m1_read_data               (m1_read_data),
    .m1_read_data_valid         (m1_read_data_valid),
    .system_bus_ready           (system_bus_ready),
    .system_bus_addr            (system_bus_addr),
    .system_bus_write_data      (system_bus_write_data),
    .system_bus_byte_enable     (system_bus_byte_enable),
    .system_bus_write_req       (system_bus_write_req),
    .system_bus_read_req        (system_bus_read_req),
    .system_bus_read_data       (system_bus_read_data),
    .system_bus_read_data_valid (system_bus_read_data_valid),
    .unexpected_read_data       (unexpected_read_data)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_idle();
    m0_addr = '0; m0_write_data = '0; m0_byte_enable = '0; m0_write_req = 0; m0_read_req = 0;
    m1_addr = '0; m1_write_data = '0; m1_byte_enable = '0; m1_write_req = 0; m1_read_req = 0;
    system_bus_ready = 1'b1;
    system_bus_read_data = '0;
    system_bus_read_data_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    system_bus_read_data       = data;
    system_bus_read_data_valid = 1'b1;
    to_edge();
    system_bus_read_data_valid = 1'b0;
  endtask

  // Scoreboard monitor: each response strobe must match the oldest expected {master, data}.
  always @(negedge clk) begin
    logic [32:0] exp_item;
    logic [32:0] act_item;
    if (m0_read_data_valid || m1_read_data_valid) begin
      act_item = {m1_read_data_valid, m1_read_data_valid ? m1_read_data : m0_read_data};
      compared++;
      if (m0_read_data_valid && m1_read_data_valid) begin
        mismatched++;
        $display("[TB] FAIL resp_onehot: got both valids, expected one at %0t", $time);
      end else if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL resp_spurious: got {id,data}=0x%09h, expected none at %0t", act_item, $time);
      end else begin
        exp_item = exp_q.pop_front();
        if (act_item !== exp_item) begin
          mismatched++;
          $display("[TB] FAIL resp_route: got {id,data}=0x%09h, expected 0x%09h at %0t", act_item, exp_item, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_stimulus_idle();
    reset = 1'b1;
    m0_read_req = 1'b1;
    m0_addr = 32'h0000_0040;
    #2;
    check_output("rst_sys_addr", system_bus_addr, 32'h0);
    check_output("rst_sys_rd", {31'b0, system_bus_read_req}, 32'h0);
    check_output("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
    check_output("rst_unexp", {31'b0, unexpected_read_data}, 32'h0);
    apply_stimulus_idle();
    to_edge();
    reset = 1'b0;
    to_edge();

    // Single m0 read, response three cycles later
    m0_read_req = 1'b1; m0_addr = 32'h100;
    @(negedge clk);
    check_output("t1_sys_addr", system_bus_addr, 32'h100);
    check_output("t1_sys_rd", {31'b0, system_bus_read_req}, 32'h1);
    check_output("t1_m0_ready", {31'b0, m0_ready}, 32'h1);
    check_output("t1_m1_ready", {31'b0, m1_ready}, 32'h0);
    to_edge();
    m0_read_req = 1'b0;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    to_edge();
    to_edge();
    respond(32'hDEAD_BEEF);

    // Simultaneous requests after reset: m0 first, then m1
    reset = 1'b1;
    to_edge();
    reset = 1'b0;
    m0_read_req = 1'b1; m0_addr = 32'h200;
    m1_read_req = 1'b1; m1_addr = 32'h204;
    @(negedge clk);
    check_output("t2_first_addr", system_bus_addr, 32'h200);
    check_output("t2_first_m0_ready", {31'b0, m0_ready}, 32'h1);
    check_output("t2_first_m1_ready", {31'b0, m1_ready}, 32'h0);
    to_edge();
    m0_read_req = 1'b0;
    @(negedge clk);
    check_output("t2_second_addr", system_bus_addr, 32'h204);
    check_output("t2_second_m1_ready", {31'b0, m1_ready}, 32'h1);
    to_edge();
    m1_read_req = 1'b0;
    exp_q.push_back({1'b0, 32'hAAAA_0001});
    exp_q.push_back({1'b1, 32'hBBBB_0002});
    to_edge();
    respond(32'hAAAA_0001);
    respond(32'hBBBB_0002);

    // m1 locked while bus stalls for four cycles, m0 waiting
    system_bus_ready = 1'b0;
    m1_write_req = 1'b1; m1_addr = 32'h300; m1_write_data = 32'h55; m1_byte_enable = 4'hF;
    @(negedge clk);
    check_output("t3_c1_addr", system_bus_addr, 32'h300);
    check_output("t3_c1_m1_ready", {31'b0, m1_ready}, 32'h0);
    to_edge();
    m0_read_req = 1'b1; m0_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("t3_lock_addr", system_bus_addr, 32'h300);
      check_output("t3_lock_m0_ready", {31'b0, m0_ready}, 32'h0);
      to_edge();
    end
    system_bus_ready = 1'b1;
    @(negedge clk);
    check_output("t3_c5_addr", system_bus_addr, 32'h300);
    check_output("t3_c5_wdata", system_bus_write_data, 32'h55);
    check_output("t3_c5_wr", {31'b0, system_bus_write_req}, 32'h1);
    check_output("t3_c5_m1_ready", {31'b0, m1_ready}, 32'h1);
    to_edge();
    m1_write_req = 1'b0;
    @(negedge clk);
    check_output("t3_m0_addr", system_bus_addr, 32'h400);
    check_output("t3_m0_ready", {31'b0, m0_ready}, 32'h1);
    to_edge();
    m0_read_req = 1'b0;
    exp_q.push_back({1'b0, 32'hCCCC_0003});
    respond(32'hCCCC_0003);

    // Fill the ID FIFO, write while full, then a response unblocks the next read
    m0_read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h500 + 32'(4 * i);
      @(negedge clk);
      check_output("t4_fill_m0_ready", {31'b0, m0_ready}, 32'h1);
      to_edge();
      exp_q.push_back({1'b0, 32'hD0 + 32'(i)});
    end
    m0_read_req = 1'b0;
    m1_write_req = 1'b1; m1_addr = 32'h600;
    @(negedge clk);
    check_output("t4_full_wr_ready", {31'b0, m1_ready}, 32'h1);
    check_output("t4_full_wr_req", {31'b0, system_bus_write_req}, 32'h1);
    to_edge();
    m1_write_req = 1'b0;
    m0_read_req = 1'b1; m0_addr = 32'h510;
    @(negedge clk);
    check_output("t4_full_rd_ready", {31'b0, m0_ready}, 32'h0);
    check_output("t4_full_rd_req", {31'b0, system_bus_read_req}, 32'h0);
    to_edge();
    system_bus_read_data = 32'hD0;
    system_bus_read_data_valid = 1'b1;
    @(negedge clk);
    check_output("t4_pop_same_cycle_ready", {31'b0, m0_ready}, 32'h0);
    to_edge();
    system_bus_read_data_valid = 1'b0;
    @(negedge clk);
    check_output("t4_unblock_ready", {31'b0, m0_ready}, 32'h1);
    check_output("t4_unblock_rd_req", {31'b0, system_bus_read_req}, 32'h1);
    check_output("t4_unblock_addr", system_bus_addr, 32'h510);
    to_edge();
    m0_read_req = 1'b0;
    exp_q.push_back({1'b0, 32'hD4});
    for (int i = 1; i <= 4; i++) respond(32'hD0 + 32'(i));

    // Response with nothing outstanding
    @(negedge clk);
    check_output("t5_flag_before", {31'b0, unexpected_read_data}, 32'h0);
    to_edge();
    system_bus_read_data = 32'hBAD;
    system_bus_read_data_valid = 1'b1;
    @(negedge clk);
    check_output("t5_m0_valid", {31'b0, m0_read_data_valid}, 32'h0);
    check_output("t5_m1_valid", {31'b0, m1_read_data_valid}, 32'h0);
    to_edge();
    system_bus_read_data_valid = 1'b0;
    @(negedge clk);
    check_output("t5_flag_set", {31'b0, unexpected_read_data}, 32'h1);
    to_edge();
    to_edge();
    @(negedge clk);
    check_output("t5_flag_held", {31'b0, unexpected_read_data}, 32'h1);
    to_edge();
    reset = 1'b1;
    #1;
    check_output("t5_flag_reset", {31'b0, unexpected_read_data}, 32'h0);
    to_edge();
    reset = 1'b0;

    // Reset with reads outstanding and m1 locked
    m0_read_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m0_addr = 32'h800 + 32'(4 * i);
      to_edge();
      exp_q.push_back({1'b0, 32'h800 + 32'(i)});
    end
    m0_read_req = 1'b0;
    system_bus_ready = 1'b0;
    m1_write_req = 1'b1; m1_addr = 32'h900;
    to_edge();
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_output("t6_rst_addr", system_bus_addr, 32'h0);
    check_output("t6_rst_wr", {31'b0, system_bus_write_req}, 32'h0);
    check_output("t6_rst_m1_ready", {31'b0, m1_ready}, 32'h0);
    check_output("t6_rst_m0_ready", {31'b0, m0_ready}, 32'h0);
    to_edge();
    m1_write_req = 1'b0;
    system_bus_ready = 1'b1;
    reset = 1'b0;
    respond(32'h0000_0123);
    @(negedge clk);
    check_output("t6_late_flag", {31'b0, unexpected_read_data}, 32'h1);
    to_edge();
    m0_read_req = 1'b1; m0_addr = 32'h700;
    @(negedge clk);
    check_output("t6_post_addr", system_bus_addr, 32'h700);
    check_output("t6_post_m0_ready", {31'b0, m0_ready}, 32'h1);
    to_edge();
    m0_read_req = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_0077});
    respond(32'h0000_0077);
    to_edge();

    check_output("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
